// File: rtl/rvz_pkg.sv
// ============================================================================
// Module      : rvz_pkg
// Description : Shared RV32I opcodes, format classes and NOP word for the
//               fetch/decode/execute slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvz_pkg;

    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    localparam logic [31:0] c_nop_inst = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        reg_we;
        logic        illegal;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/riscv_zero_imm_gen.sv
// ============================================================================
// Module      : riscv_zero_imm_gen
// Description : Combinational sign-extended immediate extraction per format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_zero_imm_gen
    import rvz_pkg::*;
(
    input  logic [31:0] inst,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    // Opcode bits never contribute to any immediate.
    logic w_unused_opc;
    assign w_unused_opc = ^inst[6:0];

    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_zero_decode.sv
// ============================================================================
// Module      : riscv_zero_decode
// Description : RV32I decode stage with output + skid register, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_zero_decode
    import rvz_pkg::*;
#(
    parameter logic [31:0] NOP_INST = c_nop_inst
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_inst,
    output logic        e_valid,
    input  logic        e_ready,
    output logic [31:0] e_pc,
    output logic [31:0] e_inst,
    output logic [4:0]  e_rd,
    output logic [4:0]  e_rs1,
    output logic [4:0]  e_rs2,
    output logic [2:0]  e_funct3,
    output logic        e_funct7b5,
    output logic [31:0] e_imm,
    output logic [2:0]  e_fmt,
    output logic        e_reg_we,
    output logic        e_illegal
);

    logic [6:0]  w_opc;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic        w_f7_ok;
    logic        w_is_shift;
    fmt_e        w_fmt;
    logic        w_we_raw;
    logic [31:0] w_imm;
    dec_t        w_dec;
    logic        w_push;
    logic        w_pop;

    dec_t        r_out;
    logic        r_out_v;
    dec_t        r_skid;
    logic        r_skid_v;

    assign w_opc      = f_inst[6:0];
    assign w_funct3   = f_inst[14:12];
    assign w_funct7   = f_inst[31:25];
    // funct7=0x20 only selects SUB (funct3 000) and SRA/SRAI (funct3 101).
    assign w_f7_ok    = (w_funct7 == 7'h00) ||
                        ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    always_comb begin
        w_fmt    = FMT_ILL;
        w_we_raw = 1'b0;
        case (w_opc)
            c_opc_lui, c_opc_auipc: begin w_fmt = FMT_U; w_we_raw = 1'b1; end
            c_opc_jal:              begin w_fmt = FMT_J; w_we_raw = 1'b1; end
            c_opc_jalr, c_opc_load: begin w_fmt = FMT_I; w_we_raw = 1'b1; end
            c_opc_branch:           w_fmt = FMT_B;
            c_opc_store:            w_fmt = FMT_S;
            c_opc_misc_mem:         w_fmt = FMT_I;
            c_opc_system:           w_fmt = FMT_SYS;
            c_opc_op_imm: begin
                if (!w_is_shift || w_f7_ok) begin
                    w_fmt    = FMT_I;
                    w_we_raw = 1'b1;
                end
            end
            c_opc_op: begin
                if (w_f7_ok) begin
                    w_fmt    = FMT_R;
                    w_we_raw = 1'b1;
                end
            end
            default:                w_fmt = FMT_ILL;
        endcase
    end

    riscv_zero_imm_gen u_imm_gen (
        .inst (f_inst),
        .fmt  (w_fmt),
        .imm  (w_imm)
    );

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = f_pc;
        w_dec.inst     = f_inst;
        w_dec.rd       = f_inst[11:7];
        w_dec.rs1      = f_inst[19:15];
        w_dec.rs2      = f_inst[24:20];
        w_dec.funct3   = w_funct3;
        w_dec.funct7b5 = f_inst[30];
        w_dec.imm      = w_imm;
        w_dec.fmt      = w_fmt;
        w_dec.reg_we   = w_we_raw && (f_inst[11:7] != 5'd0);
        w_dec.illegal  = (w_fmt == FMT_ILL);
    end

    assign f_ready = ~r_skid_v;
    assign w_push  = f_valid & f_ready;
    assign w_pop   = r_out_v & e_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out    <= '0;
            r_out_v  <= 1'b0;
            r_skid   <= '0;
            r_skid_v <= 1'b0;
        end else if (flush) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_out_v || w_pop) begin
            // Skid can only be full while output is full, so no push here.
            if (r_skid_v) begin
                r_out    <= r_skid;
                r_out_v  <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_push) begin
                r_out    <= w_dec;
                r_out_v  <= 1'b1;
            end else begin
                r_out_v  <= 1'b0;
            end
        end else if (w_push) begin
            r_skid   <= w_dec;
            r_skid_v <= 1'b1;
        end
    end

    assign e_valid    = r_out_v;
    assign e_pc       = r_out.pc;
    assign e_inst     = r_out_v ? r_out.inst : NOP_INST;
    assign e_rd       = r_out.rd;
    assign e_rs1      = r_out.rs1;
    assign e_rs2      = r_out.rs2;
    assign e_funct3   = r_out.funct3;
    assign e_funct7b5 = r_out.funct7b5;
    assign e_imm      = r_out.imm;
    assign e_fmt      = r_out.fmt;
    assign e_reg_we   = r_out_v & r_out.reg_we;
    assign e_illegal  = r_out_v & r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_riscv_zero_decode.sv
// ============================================================================
// Module      : tb_riscv_zero_decode
// Description : Directed vector and sequence bench for riscv_zero_decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_zero_decode;
    import rvz_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, f_valid, f_ready, e_valid, e_ready;
    logic [31:0] f_pc, f_inst, e_pc, e_inst, e_imm;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [2:0]  e_funct3, e_fmt;
    logic        e_funct7b5, e_reg_we, e_illegal;

    int total = 0;
    int bad   = 0;

    riscv_zero_decode #(.NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_inst(f_inst),
        .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_inst(e_inst),
        .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2), .e_funct3(e_funct3),
        .e_funct7b5(e_funct7b5), .e_imm(e_imm), .e_fmt(e_fmt),
        .e_reg_we(e_reg_we), .e_illegal(e_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        b5, we, ill;
    } vec_t;

    vec_t vecs[14];
    logic [31:0] got_q[$];
    logic [31:0] seq_inst[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, FMT_I,   32'h00000005, 5'd1,  5'd0, 5'd5,  3'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'hFE208EE3, FMT_B,   32'hFFFFFFFC, 5'd29, 5'd1, 5'd2,  3'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h00000000, FMT_ILL, 32'h00000000, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h40007033, FMT_ILL, 32'h00000000, 5'd0,  5'd0, 5'd0,  3'd7, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h402081B3, FMT_R,   32'h00000000, 5'd3,  5'd1, 5'd2,  3'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h123452B7, FMT_U,   32'h12345000, 5'd5,  5'd8, 5'd3,  3'd5, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'hFE20AC23, FMT_S,   32'hFFFFFFF8, 5'd24, 5'd1, 5'd2,  3'd2, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h008000EF, FMT_J,   32'h00000008, 5'd1,  5'd0, 5'd8,  3'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h40109093, FMT_ILL, 32'h00000000, 5'd1,  5'd1, 5'd1,  3'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h4030D113, FMT_I,   32'h00000403, 5'd2,  5'd1, 5'd3,  3'd5, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h00000073, FMT_SYS, 32'h00000000, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00000013, FMT_I,   32'h00000000, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'hFFF02383, FMT_I,   32'hFFFFFFFF, 5'd7,  5'd0, 5'd31, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{32'h0000007F, FMT_ILL, 32'h00000000, 5'd0,  5'd0, 5'd0,  3'd0, 1'b0, 1'b0, 1'b1};
        seq_inst[0] = 32'h00100093;
        seq_inst[1] = 32'h00200113;
        seq_inst[2] = 32'h00300193;

        reset = 1'b0; flush = 1'b0; f_valid = 1'b0; e_ready = 1'b0;
        f_pc = 32'h0; f_inst = 32'h0;
        tick(); tick();
        reset = 1'b1;

        chk("rst_e_valid", {31'd0, e_valid}, 32'd0);
        chk("rst_f_ready", {31'd0, f_ready}, 32'd1);
        chk("rst_e_inst", e_inst, 32'h00000013);
        chk("rst_e_pc", e_pc, 32'h0);
        chk("rst_we_ill", {30'd0, e_reg_we, e_illegal}, 32'd0);

        // Streaming decode: each vector pops the previous one on its own edge.
        e_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            f_valid = 1'b1;
            f_inst  = vecs[i].inst;
            f_pc    = (i == 0) ? 32'h0 : 32'h100 + 32'(i * 4);
            tick();
            f_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, e_valid}, 32'd1);
            chk($sformatf("v%0d_inst", i), e_inst, vecs[i].inst);
            chk($sformatf("v%0d_pc", i), e_pc, (i == 0) ? 32'h0 : 32'h100 + 32'(i * 4));
            chk($sformatf("v%0d_fmt", i), {29'd0, e_fmt}, {29'd0, vecs[i].fmt});
            chk($sformatf("v%0d_imm", i), e_imm, vecs[i].imm);
            chk($sformatf("v%0d_regs", i), {17'd0, e_rd, e_rs1, e_rs2},
                {17'd0, vecs[i].rd, vecs[i].rs1, vecs[i].rs2});
            chk($sformatf("v%0d_f3b5", i), {28'd0, e_funct3, e_funct7b5},
                {28'd0, vecs[i].f3, vecs[i].b5});
            chk($sformatf("v%0d_we_ill", i), {30'd0, e_reg_we, e_illegal},
                {30'd0, vecs[i].we, vecs[i].ill});
        end
        // Last vector was illegal; once popped, the masked outputs must idle.
        tick();
        chk("idle_valid", {31'd0, e_valid}, 32'd0);
        chk("idle_inst", e_inst, 32'h00000013);
        chk("idle_we_ill", {30'd0, e_reg_we, e_illegal}, 32'd0);

        // Back-pressure: three offers with execute stalled, then drain in order.
        e_ready = 1'b0;
        f_valid = 1'b1; f_inst = seq_inst[0]; f_pc = 32'h200;
        tick();
        chk("bp_first_valid", {31'd0, e_valid}, 32'd1);
        chk("bp_ready_after1", {31'd0, f_ready}, 32'd1);
        f_inst = seq_inst[1]; f_pc = 32'h204;
        tick();
        chk("bp_ready_after2", {31'd0, f_ready}, 32'd0);
        chk("bp_head_hold", e_inst, seq_inst[0]);
        f_inst = seq_inst[2]; f_pc = 32'h208;
        tick();
        chk("bp_ready_stall", {31'd0, f_ready}, 32'd0);
        chk("bp_head_hold2", e_inst, seq_inst[0]);
        e_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 12 && got_q.size() < 3; c++) begin
            logic acc;
            acc = f_valid && f_ready;
            if (e_valid && e_ready) got_q.push_back(e_inst);
            tick();
            if (acc) f_valid = 1'b0;
        end
        chk("bp_pop_count", 32'(got_q.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("bp_order%0d", k), (k < got_q.size()) ? got_q[k] : 32'hDEADBEEF, seq_inst[k]);
        chk("bp_drained", {31'd0, e_valid}, 32'd0);

        // Flush with both entries full and a third offer in flight.
        e_ready = 1'b0;
        f_valid = 1'b1; f_inst = 32'h00A00513; tick();
        f_inst = 32'h00B00593; tick();
        chk("fl_full", {31'd0, f_ready}, 32'd0);
        f_inst = 32'h00C00613; flush = 1'b1;
        tick();
        flush = 1'b0; f_valid = 1'b0;
        chk("fl_valid", {31'd0, e_valid}, 32'd0);
        chk("fl_ready", {31'd0, f_ready}, 32'd1);
        chk("fl_inst", e_inst, 32'h00000013);
        e_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                if (e_valid) seen++;
                tick();
            end
            chk("fl_none_appear", 32'(seen), 32'd0);
        end
        // Flush while empty drops the same-cycle transfer.
        f_valid = 1'b1; f_inst = 32'h00D00693; flush = 1'b1;
        tick();
        flush = 1'b0; f_valid = 1'b0;
        chk("fl_drop_xfer", {31'd0, e_valid}, 32'd0);

        // Reset with two entries held.
        e_ready = 1'b0;
        f_valid = 1'b1; f_inst = 32'h00500093; f_pc = 32'h300; tick();
        f_inst = 32'h00600113; f_pc = 32'h304; tick();
        f_valid = 1'b0;
        chk("rs_full", {31'd0, f_ready}, 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rs_valid", {31'd0, e_valid}, 32'd0);
        chk("rs_ready", {31'd0, f_ready}, 32'd1);
        chk("rs_inst", e_inst, 32'h00000013);
        chk("rs_pc", e_pc, 32'h0);

        // Reset wins over a same-cycle transfer.
        f_valid = 1'b1; f_inst = 32'h00700193; reset = 1'b0;
        tick();
        reset = 1'b1; f_valid = 1'b0;
        chk("rs_over_xfer", {31'd0, e_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
